// File: rtl/reg_file_arb_pkg.sv
// Shared types and helpers for the register-file arbiter.
package reg_file_arb_pkg;

  // Upper bound on requesters; index type is sized for it.
  localparam int unsigned MAX_REQ = 4;

  typedef logic [1:0] req_idx_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Convert a one-hot (or all-zero) vector to its bit index; zero maps to 0.
  function automatic req_idx_t onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    req_idx_t idx;
    idx = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (oh[k]) idx = req_idx_t'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/reg_file_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter. The last-grant pointer is owned by the
// caller so it can be held or reset independently of the request pattern.
module rr_arbiter
  import reg_file_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           last,
  output logic [NUM_REQ-1:0] gnt,
  output req_idx_t           gnt_idx
);

  logic               w_found;
  logic [MAX_REQ-1:0] w_gnt_pad;

  // Scan upward from last+1 with wrap; first asserted request wins.
  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!w_found && req[j] && (j == (32'(last) + i) % NUM_REQ)) begin
          gnt[j]  = 1'b1;
          w_found = 1'b1;
        end
      end
    end
  end

  // Encode the one-hot grant as an index for the data muxes and pointer.
  always_comb begin
    w_gnt_pad              = '0;
    w_gnt_pad[NUM_REQ-1:0] = gnt;
    gnt_idx                = onehot_to_idx(w_gnt_pad);
  end

endmodule

// File: rtl/reg_file_arbiter.sv
// Shares one register file (1 write port, 1 async read port) between
// NUM_REQ requesters with independent round-robin write/read arbitration,
// registered read responses and a zero-fill sequence after reset.
module reg_file_arbiter
  import reg_file_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned NUM_REQ    = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               wr_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wr_data,
  output logic [NUM_REQ-1:0]               wr_gnt,
  input  logic [NUM_REQ-1:0]               rd_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    rd_addr,
  output logic [NUM_REQ-1:0]               rd_gnt,
  output logic [NUM_REQ-1:0]               rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]            rd_rsp_data,
  output logic                             init_done,
  output logic                             rf_we,
  output logic [ADDR_WIDTH-1:0]            rf_w_address,
  output logic [DATA_WIDTH-1:0]            rf_w_data,
  output logic [ADDR_WIDTH-1:0]            rf_r_address,
  input  logic [DATA_WIDTH-1:0]            rf_r_data
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_init_cnt;
  logic                    r_init_done;
  req_idx_t                r_wr_last;
  req_idx_t                r_rd_last;
  logic [NUM_REQ-1:0]      r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_data;

  logic [NUM_REQ-1:0]      w_wr_req_run;
  logic [NUM_REQ-1:0]      w_rd_req_run;
  logic [NUM_REQ-1:0]      w_wr_gnt;
  logic [NUM_REQ-1:0]      w_rd_gnt;
  req_idx_t                w_wr_idx;
  req_idx_t                w_rd_idx;
  logic [ADDR_WIDTH-1:0]   w_wr_addr_sel;
  logic [DATA_WIDTH-1:0]   w_wr_data_sel;
  logic                    w_fwd;
  logic [DATA_WIDTH-1:0]   w_rd_sel_data;

  // Requests are masked during INIT so neither arbiter can grant.
  assign w_wr_req_run = (r_state == ST_RUN) ? wr_req : '0;
  assign w_rd_req_run = (r_state == ST_RUN) ? rd_req : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .req     (w_wr_req_run),
    .last    (r_wr_last),
    .gnt     (w_wr_gnt),
    .gnt_idx (w_wr_idx)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .req     (w_rd_req_run),
    .last    (r_rd_last),
    .gnt     (w_rd_gnt),
    .gnt_idx (w_rd_idx)
  );

  // With no grant the index is 0, so idle cycles present requester 0's fields.
  assign w_wr_addr_sel = wr_addr[w_wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wr_data_sel = wr_data[w_wr_idx*DATA_WIDTH +: DATA_WIDTH];
  assign rf_r_address  = rd_addr[w_rd_idx*ADDR_WIDTH +: ADDR_WIDTH];

  assign wr_gnt        = w_wr_gnt;
  assign rd_gnt        = w_rd_gnt;
  assign rd_rsp_valid  = r_rsp_valid;
  assign rd_rsp_data   = r_rsp_data;
  assign init_done     = r_init_done;

  // Next state and register-file write port: zero-fill in INIT, arbitrated in RUN.
  always_comb begin
    w_state_nxt  = r_state;
    rf_we        = 1'b0;
    rf_w_address = w_wr_addr_sel;
    rf_w_data    = w_wr_data_sel;
    unique case (r_state)
      ST_INIT: begin
        rf_we        = 1'b1;
        rf_w_address = r_init_cnt;
        rf_w_data    = '0;
        if (r_init_cnt == '1) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        rf_we = |w_wr_gnt;
      end
    endcase
  end

  // A same-cycle write to the address being read is forwarded into the response.
  assign w_fwd         = (|w_wr_gnt) && (|w_rd_gnt) && (rf_w_address == rf_r_address);
  assign w_rd_sel_data = w_fwd ? rf_w_data : rf_r_data;

  // State, zero-fill counter, grant pointers and the registered read response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
      r_wr_last   <= req_idx_t'(NUM_REQ - 1);
      r_rd_last   <= req_idx_t'(NUM_REQ - 1);
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + 1'b1;
        if (r_init_cnt == '1) r_init_done <= 1'b1;
      end
      if (|w_wr_gnt) r_wr_last <= w_wr_idx;
      if (|w_rd_gnt) begin
        r_rd_last  <= w_rd_idx;
        r_rsp_data <= w_rd_sel_data;
      end
      r_rsp_valid <= w_rd_gnt;
    end
  end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed testbench for reg_file_arbiter with a behavioural register file.
module tb_reg_file_arbiter;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     wr_req = '0;
  logic [NR*AW-1:0]  wr_addr = '0;
  logic [NR*DW-1:0]  wr_data = '0;
  logic [NR-1:0]     wr_gnt;
  logic [NR-1:0]     rd_req = '0;
  logic [NR*AW-1:0]  rd_addr = '0;
  logic [NR-1:0]     rd_gnt;
  logic [NR-1:0]     rd_rsp_valid;
  logic [DW-1:0]     rd_rsp_data;
  logic              init_done;
  logic              rf_we;
  logic [AW-1:0]     rf_w_address;
  logic [DW-1:0]     rf_w_data;
  logic [AW-1:0]     rf_r_address;
  logic [DW-1:0]     rf_r_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  // Register file: synchronous write, asynchronous read.
  always @(posedge clk) begin
    if (rf_we) mem[rf_w_address] <= rf_w_data;
  end
  assign rf_r_data = mem[rf_r_address];

  reg_file_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REQ    (NR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_gnt       (wr_gnt),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_gnt       (rd_gnt),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .init_done    (init_done),
    .rf_we        (rf_we),
    .rf_w_address (rf_w_address),
    .rf_w_data    (rf_w_data),
    .rf_r_address (rf_r_address),
    .rf_r_data    (rf_r_data)
  );

  // Returns at the negedge that opens cycle 0 after reset release.
  task automatic reset_dut();
    reset   = 1'b1;
    wr_req  = '0;
    rd_req  = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_write(input int r, input int a, input logic [DW-1:0] d);
    logic [NR-1:0] oh;
    oh = '0;
    oh[r] = 1'b1;
    wr_req = oh;
    wr_addr[r*AW +: AW] = 3'(a);
    wr_data[r*DW +: DW] = d;
    #1;
    n_tests++;
    if (wr_gnt !== oh || rf_we !== 1'b1 || rf_w_address !== 3'(a) || rf_w_data !== d) begin
      n_fail++;
      $display("FAIL write a=%0d: gnt=%b we=%b addr=%0d data=%h, expected gnt=%b we=1 addr=%0d data=%h",
               a, wr_gnt, rf_we, rf_w_address, rf_w_data, oh, a, d);
    end
    @(negedge clk);
    wr_req = '0;
  endtask

  task automatic do_read(input int r, input int a, input logic [DW-1:0] exp);
    logic [NR-1:0] oh;
    oh = '0;
    oh[r] = 1'b1;
    rd_req = oh;
    rd_addr[r*AW +: AW] = 3'(a);
    #1;
    n_tests++;
    if (rd_gnt !== oh || rf_r_address !== 3'(a)) begin
      n_fail++;
      $display("FAIL read_gnt a=%0d: gnt=%b raddr=%0d, expected gnt=%b raddr=%0d",
               a, rd_gnt, rf_r_address, oh, a);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (rd_rsp_valid !== oh || rd_rsp_data !== exp) begin
      n_fail++;
      $display("FAIL read_rsp a=%0d: valid=%b data=%h, expected valid=%b data=%h",
               a, rd_rsp_valid, rd_rsp_data, oh, exp);
    end
    rd_req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_dut();
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c == 0) begin
        n_tests++;
        if (rd_rsp_valid !== 2'b00 || rd_rsp_data !== 8'h00) begin
          n_fail++;
          $display("FAIL reset_rsp: valid=%b data=%h, expected 00/00", rd_rsp_valid, rd_rsp_data);
        end
      end
      if (c < 8) begin
        n_tests++;
        if (init_done !== 1'b0 || rf_we !== 1'b1 || rf_w_address !== 3'(c) || rf_w_data !== 8'h00) begin
          n_fail++;
          $display("FAIL zero_fill c=%0d: done=%b we=%b addr=%0d data=%h, expected 0/1/%0d/00",
                   c, init_done, rf_we, rf_w_address, rf_w_data, c);
        end
        n_tests++;
        if (wr_gnt !== 2'b00 || rd_gnt !== 2'b00) begin
          n_fail++;
          $display("FAIL init_gnt c=%0d: wr=%b rd=%b, expected 00/00", c, wr_gnt, rd_gnt);
        end
      end else begin
        n_tests++;
        if (init_done !== 1'b1 || rf_we !== 1'b0) begin
          n_fail++;
          $display("FAIL init_done c=%0d: done=%b we=%b, expected 1/0", c, init_done, rf_we);
        end
      end
      @(negedge clk);
    end
    for (int a = 0; a < 8; a++) do_read(0, a, 8'h00);
  endtask

  task automatic test_single();
    for (int i = 0; i < 8; i++) do_write(0, i, 8'(i * 10));
    for (int i = 0; i < 8; i++) do_read(0, i, 8'(i * 10));
  endtask

  task automatic test_forwarding();
    do_read(0, 3, 8'd30);
    wr_req = 2'b01;
    wr_addr[0 +: AW] = 3'd3;
    wr_data[0 +: DW] = 8'hA5;
    rd_req = 2'b10;
    rd_addr[AW +: AW] = 3'd3;
    #1;
    n_tests++;
    if (wr_gnt !== 2'b01 || rd_gnt !== 2'b10) begin
      n_fail++;
      $display("FAIL fwd_gnt: wr=%b rd=%b, expected 01/10", wr_gnt, rd_gnt);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (rd_rsp_valid !== 2'b10 || rd_rsp_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL fwd_rsp: valid=%b data=%h, expected 10/a5", rd_rsp_valid, rd_rsp_data);
    end
    wr_req = '0;
    rd_req = '0;
    @(negedge clk);
    do_read(0, 3, 8'hA5);
  endtask

  task automatic test_contention();
    logic [NR-1:0] exp;
    logic [NR-1:0] prev;
    reset_dut();
    repeat (8) @(negedge clk);
    // First RUN cycle, idle: check idle read-address selection.
    rd_addr = {3'd1, 3'd6};
    #1;
    n_tests++;
    if (rf_we !== 1'b0 || rf_r_address !== 3'd6 || init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL idle: we=%b raddr=%0d done=%b, expected 0/6/1", rf_we, rf_r_address, init_done);
    end
    wr_req  = 2'b11;
    wr_addr = {3'd5, 3'd2};
    wr_data = {8'h22, 8'h11};
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_tests++;
      if (wr_gnt !== exp || rf_w_address !== ((k % 2 == 0) ? 3'd2 : 3'd5) ||
          rf_w_data !== ((k % 2 == 0) ? 8'h11 : 8'h22)) begin
        n_fail++;
        $display("FAIL wr_rr k=%0d: gnt=%b addr=%0d data=%h, expected gnt=%b", k, wr_gnt,
                 rf_w_address, rf_w_data, exp);
      end
      @(negedge clk);
    end
    wr_req  = '0;
    rd_req  = 2'b11;
    rd_addr = {3'd5, 3'd2};
    prev    = '0;
    for (int k = 0; k < 3; k++) begin
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_tests++;
      if (rd_gnt !== exp) begin
        n_fail++;
        $display("FAIL rd_rr k=%0d: gnt=%b, expected %b", k, rd_gnt, exp);
      end
      if (k > 0) begin
        n_tests++;
        if (rd_rsp_valid !== prev || rd_rsp_data !== ((prev == 2'b01) ? 8'h11 : 8'h22)) begin
          n_fail++;
          $display("FAIL rd_rr_rsp k=%0d: valid=%b data=%h, expected valid=%b", k, rd_rsp_valid,
                   rd_rsp_data, prev);
        end
      end
      prev = exp;
      @(negedge clk);
    end
    // Write pointer last granted 1, read pointer last granted 0.
    wr_req = 2'b11;
    rd_req = 2'b11;
    #1;
    n_tests++;
    if (rd_rsp_valid !== 2'b01 || rd_rsp_data !== 8'h11) begin
      n_fail++;
      $display("FAIL rd_rr_last_rsp: valid=%b data=%h, expected 01/11", rd_rsp_valid, rd_rsp_data);
    end
    n_tests++;
    if (wr_gnt !== 2'b01 || rd_gnt !== 2'b10) begin
      n_fail++;
      $display("FAIL ptr_indep: wr=%b rd=%b, expected 01/10", wr_gnt, rd_gnt);
    end
    @(negedge clk);
    wr_req = '0;
    rd_req = '0;
  endtask

  task automatic test_reset_midrun();
    rd_req = 2'b01;
    rd_addr[0 +: AW] = 3'd5;
    reset = 1'b1;
    #1;
    n_tests++;
    if (rd_gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL midrun_gnt: gnt=%b, expected 01", rd_gnt);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (rd_rsp_valid !== 2'b00 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: valid=%b done=%b, expected 00/0", rd_rsp_valid, init_done);
    end
    @(negedge clk);
    rd_req = '0;
    reset  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_tests++;
      if (rf_we !== 1'b1 || rf_w_address !== 3'(c) || rf_w_data !== 8'h00 || rd_rsp_valid !== 2'b00) begin
        n_fail++;
        $display("FAIL refill c=%0d: we=%b addr=%0d data=%h valid=%b, expected 1/%0d/00/00",
                 c, rf_we, rf_w_address, rf_w_data, rd_rsp_valid, c);
      end
      @(negedge clk);
    end
    do_read(0, 2, 8'h00);
    do_read(0, 5, 8'h00);
  endtask

  task automatic test_init_requests();
    reset_dut();
    wr_req = 2'b11;
    rd_req = 2'b11;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c < 8) begin
        n_tests++;
        if (wr_gnt !== 2'b00 || rd_gnt !== 2'b00 || rf_w_address !== 3'(c)) begin
          n_fail++;
          $display("FAIL init_req c=%0d: wr=%b rd=%b addr=%0d, expected 00/00/%0d",
                   c, wr_gnt, rd_gnt, rf_w_address, c);
        end
      end else begin
        n_tests++;
        if (wr_gnt !== ((c == 8) ? 2'b01 : 2'b10) || rd_gnt !== ((c == 8) ? 2'b01 : 2'b10)) begin
          n_fail++;
          $display("FAIL init_req_run c=%0d: wr=%b rd=%b, expected %s", c, wr_gnt, rd_gnt,
                   (c == 8) ? "01/01" : "10/10");
        end
      end
      @(negedge clk);
    end
    wr_req = '0;
    rd_req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_forwarding();
    test_contention();
    test_reset_midrun();
    test_init_requests();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
